// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB slave-port signal bundle between the fabric (master side) and the SRAM slave
interface ahb_sram_slave_if #(
    parameter int DATA_W = 32
);
    logic              sHSEL;
    logic              sHREADYin;
    logic [1:0]        sHTRANS;
    logic [31:0]       sHADDR;
    logic              sHWRITE;
    logic [2:0]        sHSIZE;
    logic [2:0]        sHBURST;
    logic [DATA_W-1:0] sHWDATA;
    logic [DATA_W-1:0] sHRDATA;
    logic              sHREADY;
    logic [1:0]        sHRESP;

    modport master (
        output sHSEL, sHREADYin, sHTRANS, sHADDR, sHWRITE, sHSIZE, sHBURST, sHWDATA,
        input  sHRDATA, sHREADY, sHRESP
    );

    modport slave (
        input  sHSEL, sHREADYin, sHTRANS, sHADDR, sHWRITE, sHSIZE, sHBURST, sHWDATA,
        output sHRDATA, sHREADY, sHRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: word-addressed AHB SRAM slave with configurable wait states and two-cycle ERROR responses
module ahb_sram_slave #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic              HCLK,
    input logic              HRESET,
    ahb_sram_slave_if.slave  s
);
    localparam int BYTES = DATA_W / 8;
    localparam int ALB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    // End address kept at 33 bits so a window ending at 4 GiB does not wrap
    localparam logic [32:0] END_A = {1'b0, BASE_ADDR} + 33'(DEPTH * BYTES);

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               wr_q;
    logic               err_q;
    logic               ready_q;
    logic [1:0]         resp_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [31:0]        off;
    logic               accept;
    logic               err_in;
    logic [IDX_W-1:0]   idx_in;
    logic               unused_ok;

    assign off    = s.sHADDR - BASE_ADDR;
    assign idx_in = off[ALB +: IDX_W];
    assign accept = s.sHSEL & s.sHREADYin & s.sHTRANS[1];
    assign err_in = (s.sHADDR < BASE_ADDR)
                  | ({1'b0, s.sHADDR} >= END_A)
                  | (s.sHADDR[ALB-1:0] != '0)
                  | (s.sHSIZE != 3'(ALB));

    assign s.sHREADY = ready_q;
    assign s.sHRESP  = resp_q;
    assign s.sHRDATA = (state_q == DATA && !wr_q) ? mem_q[idx_q] : '0;

    // Burst type is irrelevant since every beat is decoded on its own
    assign unused_ok = ^{s.sHBURST, s.sHTRANS[0], off, err_q};

    // Transfer FSM: registers the address phase and produces registered HREADY/HRESP
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            resp_q  <= 2'b00;
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= DATA;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ERR1: begin
                    state_q <= ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= 2'b01;
                end
                default: begin
                    if (accept) begin
                        idx_q <= idx_in;
                        wr_q  <= s.sHWRITE;
                        err_q <= err_in;
                        if (err_in) begin
                            state_q <= ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= 2'b01;
                        end else if (WAIT_STATES > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                            ready_q <= 1'b0;
                            resp_q  <= 2'b00;
                        end else begin
                            state_q <= DATA;
                            ready_q <= 1'b1;
                            resp_q  <= 2'b00;
                        end
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= 2'b00;
                    end
                end
            endcase
        end
    end

    // Write commit at the edge closing a write data phase; reset abandons it and never clears the array
    always_ff @(posedge HCLK) begin
        if (!HRESET && state_q == DATA && wr_q) mem_q[idx_q] <= s.sHWDATA;
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed checks of a zero-wait and a three-wait instance of ahb_sram_slave
module tb_ahb_sram_slave;
    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        sel0, sel3, hwrite, nrdy;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize;
    int          cmp = 0;
    int          mis = 0;
    int          cyc, beats, nacc;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave_if #(.DATA_W(32)) if0 ();
    ahb_sram_slave_if #(.DATA_W(32)) if3 ();

    assign if0.sHSEL     = sel0;
    assign if0.sHREADYin = if0.sHREADY & ~nrdy;
    assign if0.sHTRANS   = htrans;
    assign if0.sHADDR    = haddr;
    assign if0.sHWRITE   = hwrite;
    assign if0.sHSIZE    = hsize;
    assign if0.sHBURST   = 3'b001;
    assign if0.sHWDATA   = hwdata;

    assign if3.sHSEL     = sel3;
    assign if3.sHREADYin = if3.sHREADY & ~nrdy;
    assign if3.sHTRANS   = htrans;
    assign if3.sHADDR    = haddr;
    assign if3.sHWRITE   = hwrite;
    assign if3.sHSIZE    = hsize;
    assign if3.sHBURST   = 3'b001;
    assign if3.sHWDATA   = hwdata;

    ahb_sram_slave #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .s(if0)
    );
    ahb_sram_slave #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
        .HCLK(HCLK), .HRESET(HRESET), .s(if3)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [2:0] z = 3'd2);
        htrans = t;
        haddr  = a;
        hwrite = w;
        hsize  = z;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic o0(input string tag, input logic r, input logic [1:0] p, input logic [31:0] d);
        chk({tag, ".ready"}, 32'(if0.sHREADY), 32'(r));
        chk({tag, ".resp"}, 32'(if0.sHRESP), 32'(p));
        chk({tag, ".rdata"}, if0.sHRDATA, d);
    endtask

    task automatic o3(input string tag, input logic r, input logic [1:0] p, input logic [31:0] d);
        chk({tag, ".ready"}, 32'(if3.sHREADY), 32'(r));
        chk({tag, ".resp"}, 32'(if3.sHRESP), 32'(p));
        chk({tag, ".rdata"}, if3.sHRDATA, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sel0 = 0; sel3 = 0; nrdy = 0; hwdata = 0;
        bus(2'b00, 32'h0, 1'b0);
        HRESET = 1;
        tick(); tick();
        o0("rst0", 1, 2'b00, 0);
        o3("rst3", 1, 2'b00, 0);
        HRESET = 0;

        // zero-wait write then read of 0x10
        sel0 = 1;
        bus(2'b10, 32'h10, 1'b1); tick(); o0("wr10", 1, 0, 0);
        hwdata = 32'hDEAD_BEEF;
        bus(2'b10, 32'h10, 1'b0); tick(); o0("rd10", 1, 0, 32'hDEAD_BEEF);
        bus(2'b00, 32'h0, 1'b0); tick(); o0("idle", 1, 0, 0);

        // pipelined burst, read-after-write with no bubbles
        bus(2'b10, 32'h0, 1'b1); tick(); o0("b0", 1, 0, 0);
        hwdata = 32'h1111_1111; bus(2'b11, 32'h4, 1'b1); tick(); o0("b1", 1, 0, 0);
        hwdata = 32'h2222_2222; bus(2'b11, 32'h8, 1'b1); tick(); o0("b2", 1, 0, 0);
        hwdata = 32'h3333_3333; bus(2'b10, 32'h8, 1'b0); tick(); o0("b_rd8", 1, 0, 32'h3333_3333);
        bus(2'b10, 32'h0, 1'b0); tick(); o0("b_rd0", 1, 0, 32'h1111_1111);
        bus(2'b11, 32'h4, 1'b0); tick(); o0("b_rd4", 1, 0, 32'h2222_2222);
        bus(2'b00, 32'h0, 1'b0); tick();

        // error responses, chained, then a legal transfer accepted in ERR2
        bus(2'b10, 32'h400, 1'b1); tick(); o0("e400_1", 0, 2'b01, 0);
        bus(2'b00, 32'h0, 1'b0); hwdata = 32'hBAD0_BAD0; tick(); o0("e400_2", 1, 2'b01, 0);
        bus(2'b10, 32'h2, 1'b0); tick(); o0("e2_1", 0, 2'b01, 0);
        bus(2'b00, 32'h0, 1'b0); tick(); o0("e2_2", 1, 2'b01, 0);
        bus(2'b10, 32'h10, 1'b1, 3'd0); tick(); o0("esz_1", 0, 2'b01, 0);
        bus(2'b10, 32'h10, 1'b0); tick(); o0("esz_2", 1, 2'b01, 0);
        tick(); o0("e_next", 1, 2'b00, 32'hDEAD_BEEF);
        bus(2'b10, 32'h0, 1'b0); tick(); o0("e_wrap0", 1, 2'b00, 32'h1111_1111);
        bus(2'b00, 32'h0, 1'b0); tick();

        // IDLE, BUSY and NONSEQ with fabric HREADY low are ignored
        bus(2'b00, 32'h10, 1'b0); tick(); o0("t_idle", 1, 0, 0);
        bus(2'b01, 32'h10, 1'b0); tick(); o0("t_busy", 1, 0, 0);
        nrdy = 1; bus(2'b10, 32'h10, 1'b0); tick(); o0("t_nordy", 1, 0, 0);
        nrdy = 0; bus(2'b00, 32'h0, 1'b0); sel0 = 0; tick(); o0("t_after", 1, 0, 0);

        // three wait states: write 0x20
        sel3 = 1;
        bus(2'b10, 32'h20, 1'b1); tick(); o3("w3_w1", 0, 0, 0);
        bus(2'b00, 32'h0, 1'b0); hwdata = 32'hAAAA_5555;
        tick(); o3("w3_w2", 0, 0, 0);
        tick(); o3("w3_w3", 0, 0, 0);
        tick(); o3("w3_data", 1, 0, 0);
        tick(); o3("w3_idle", 1, 0, 0);

        // read latency of WAIT_STATES+1
        bus(2'b10, 32'h20, 1'b0); tick(); o3("r3_w1", 0, 0, 0);
        bus(2'b00, 32'h0, 1'b0);
        tick(); o3("r3_w2", 0, 0, 0);
        tick(); o3("r3_w3", 0, 0, 0);
        tick(); o3("r3_data", 1, 0, 32'hAAAA_5555);
        tick();

        // four back-to-back reads take 16 cycles
        bus(2'b10, 32'h20, 1'b0);
        cyc = 0; beats = 0; nacc = 1;
        for (int i = 0; i < 40 && beats < 4; i++) begin
            tick();
            cyc++;
            if (if3.sHREADY) begin
                chk($sformatf("b2b_%0d", beats), if3.sHRDATA, 32'hAAAA_5555);
                beats++;
                if (nacc < 4) nacc++;
                else bus(2'b00, 32'h0, 1'b0);
            end
        end
        chk("b2b_beats", beats, 4);
        chk("b2b_cycles", cyc, 16);
        tick();

        // error length is independent of wait states
        bus(2'b10, 32'h2, 1'b0); tick(); o3("e3_1", 0, 2'b01, 0);
        bus(2'b00, 32'h0, 1'b0); tick(); o3("e3_2", 1, 2'b01, 0);
        tick(); o3("e3_idle", 1, 2'b00, 0);

        // reset during the wait of a write abandons it
        bus(2'b10, 32'h20, 1'b1); tick(); o3("rw_wait", 0, 0, 0);
        bus(2'b00, 32'h0, 1'b0); hwdata = 32'h1234_5678;
        tick();
        HRESET = 1; tick(); o3("rw_rst", 1, 2'b00, 0);
        HRESET = 0; tick();
        bus(2'b10, 32'h20, 1'b0); tick();
        bus(2'b00, 32'h0, 1'b0);
        tick(); tick(); tick(); o3("rw_old", 1, 2'b00, 32'hAAAA_5555);
        sel3 = 0; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB slave memory, successor to the fixed 32-bit slave bus interface. It sits on the AHB fabric as one slave port and is built as a word-addressed register/SRAM array. Each data phase can be stretched by a configurable number of wait states. Misaligned, wrong-size or out-of-range transfers get a two-cycle ERROR response. It serves as the NN calculator's operand/result store and as the fabric's wait-state and error test target.

## Interface
Parameters:
- DATA_W, 32: data bus width; one of 32 or 64.
- DEPTH, 256: number of DATA_W words; power of two, at least 2.
- WAIT_STATES, 0: HREADY-low cycles inserted per data phase; range 0..7.
- BASE_ADDR, 32'h0000_0000: byte base address; aligned to DEPTH*DATA_W/8.

Ports:
- HCLK  input  1  clock; all state updates on its rising edge.
- HRESET  input  1  synchronous, active-high reset.
- sHSEL  input  1  slave select from the decoder.
- sHREADYin  input  1  fabric HREADY; the previous transfer is complete.
- sHTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- sHADDR  input  32  byte address.
- sHWRITE  input  1  1 = write.
- sHSIZE  input  3  transfer size; only log2(DATA_W/8) is legal.
- sHBURST  input  3  accepted and ignored; each beat is treated independently.
- sHWDATA  input  DATA_W  write data, valid in the data phase.
- sHRDATA  output  DATA_W  read data.
- sHREADY  output  1  data phase complete.
- sHRESP  output  2  OKAY=00, ERROR=01.

## Operation
- Accept condition: sHSEL & sHREADYin & sHTRANS[1]. On accept, register the write flag, the word index ((sHADDR-BASE_ADDR)>>log2(DATA_W/8)) and an error flag.
- Error flag is set by any of: address below BASE_ADDR; address at or above BASE_ADDR+DEPTH*DATA_W/8; nonzero low address bits; sHSIZE ≠ log2(DATA_W/8).
- IDLE or BUSY transfer, or sHSEL low: nothing is accepted; the slave returns zero-wait OKAY.
- FSM states:
  - IDLE: sHREADY=1, sHRESP=OKAY.
  - WAIT: sHREADY=0, OKAY, counter decrements.
  - DATA: sHREADY=1, OKAY, transfer completes.
  - ERR1: sHREADY=0, ERROR.
  - ERR2: sHREADY=1, ERROR.
- Transitions on accept, from IDLE, DATA or ERR2:
  - error flag set → ERR1.
  - else WAIT_STATES>0 → WAIT, with counter = WAIT_STATES-1.
  - else → DATA.
- WAIT: counter=0 → DATA; otherwise stay in WAIT.
- ERR1 → ERR2, unconditionally. No address phase is accepted in ERR1 or WAIT; sHREADYin is low then.
- DATA or ERR2 with no accept → IDLE.
- Write commit: at the rising edge that ends DATA, mem[idx] ← sHWDATA. ERROR transfers never modify memory.
- Read: sHRDATA = mem[idx] in DATA of a read; 0 in all other states and for writes.
- Back-to-back transfers: a new accept in DATA or ERR2 chains directly into the next transfer with no idle cycle.
- Read-after-write to the same word in consecutive transfers returns the new data.
- Memory is not cleared by reset.

## Timing
- Reset: state=IDLE, counter=0, sHREADY=1, sHRESP=00, sHRDATA=0, registered address/write/error flags cleared.
- Reset asserted mid-transfer (WAIT/DATA/ERR1/ERR2): the transfer is abandoned, a pending write is not committed, and outputs take reset values the next cycle.
- Read latency: data is valid WAIT_STATES+1 cycles after the address-phase edge, in the single cycle where sHREADY=1.
- Zero-wait throughput: one transfer per cycle, sustained.
- Wait-state throughput: one transfer per WAIT_STATES+1 cycles.
- Error: exactly two cycles, ERROR with sHREADY=0 then ERROR with sHREADY=1, regardless of WAIT_STATES.
- Counter width: clog2(WAIT_STATES+1), minimum 1 bit; no wrap, since the counter is only loaded on accept.

## Test plan
- Reset with defaults: sHREADY=1, sHRESP=00, sHRDATA=0. Write 32'hDEAD_BEEF to 0x10, then read 0x10 → data returned in the cycle after the read address phase, OKAY.
- WAIT_STATES=3: a read shows sHREADY low for exactly 3 cycles, then high with data; 4 back-to-back reads take 16 data cycles.
- Pipelined NONSEQ/SEQ burst with zero waits: write 0x0,0x4,0x8 then read 0x8 immediately → returns the last-written value, no bubble cycles.
- Errors: access to 0x400 (DEPTH=256), address 0x2, or sHSIZE=0 → ERROR then ERROR+READY; the target word is unchanged when read back; the next legal transfer accepted in ERR2 completes OKAY.
- Transfer types: IDLE and BUSY with sHSEL=1, and NONSEQ with sHREADYin=0 → no state change, sHREADY=1, OKAY.
- HRESET pulsed during WAIT of a write to 0x20 → the write is not committed, outputs return to reset values, and a subsequent read of 0x20 returns its old value.
